// File: rtl/conv_output_streamer_pkg.sv
// Shared definitions for the conv layer's flat output bus: default geometry,
// derived sizes, counter-width helper and the streamer state encoding.
package conv_output_streamer_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } state_t;

  // Counter/index width for n distinct values, never below one bit.
  function automatic int cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_H          = 8;
  localparam int DEF_W          = 8;
  localparam int DEF_F          = 3;
  localparam int DEF_K          = 6;
  localparam int DEF_OH         = DEF_H - DEF_F + 1;
  localparam int DEF_OW         = DEF_W - DEF_F + 1;
  localparam int DEF_MAPSZ      = DEF_OH * DEF_OW;
  localparam int DEF_NELEM      = DEF_K * DEF_MAPSZ;

  // Bit width of the flat frame bus for a given layer geometry.
  function automatic int frame_bits(input int dw, input int h, input int w,
                                    input int f, input int k);
    return k * (h - f + 1) * (w - f + 1) * dw;
  endfunction

endpackage

// File: rtl/conv_stream_counter.sv
// Three-level nested (column, row, map) position counter with clear, enable
// and last-position flags; wraps to zero after the final position.
module conv_stream_counter
  import conv_output_streamer_pkg::*;
#(
  parameter int NC = 6,
  parameter int NR = 6,
  parameter int NM = 6,
  parameter int CW = cw(NC),
  parameter int RW = cw(NR),
  parameter int MW = cw(NM)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          clr_i,
  input  logic          en_i,
  output logic [CW-1:0] c_o,
  output logic [RW-1:0] r_o,
  output logic [MW-1:0] m_o,
  output logic          row_last_o,
  output logic          map_last_o,
  output logic          frame_last_o
);

  logic [CW-1:0] c_q, c_d;
  logic [RW-1:0] r_q, r_d;
  logic [MW-1:0] m_q, m_d;
  logic          c_end, r_end, m_end;

  assign c_end = (c_q == CW'(NC - 1));
  assign r_end = (r_q == RW'(NR - 1));
  assign m_end = (m_q == MW'(NM - 1));

  always_comb begin
    c_d = c_q;
    r_d = r_q;
    m_d = m_q;
    if (clr_i) begin
      c_d = '0;
      r_d = '0;
      m_d = '0;
    end else if (en_i) begin
      if (c_end) begin
        c_d = '0;
        if (r_end) begin
          r_d = '0;
          m_d = m_end ? '0 : m_q + 1'b1;
        end else begin
          r_d = r_q + 1'b1;
        end
      end else begin
        c_d = c_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      c_q <= '0;
      r_q <= '0;
      m_q <= '0;
    end else begin
      c_q <= c_d;
      r_q <= r_d;
      m_q <= m_d;
    end
  end

  assign c_o          = c_q;
  assign r_o          = r_q;
  assign m_o          = m_q;
  assign row_last_o   = c_end;
  assign map_last_o   = c_end & r_end;
  assign frame_last_o = c_end & r_end & m_end;

endmodule

// File: rtl/conv_output_streamer.sv
// Snapshots the conv layer's K output maps on start and streams them out one
// element per valid/ready beat, map-major then row-major, with position markers.
module conv_output_streamer
  import conv_output_streamer_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int H          = DEF_H,
  parameter int W          = DEF_W,
  parameter int F          = DEF_F,
  parameter int K          = DEF_K,
  parameter int RELU       = 0
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    start,
  input  logic [frame_bits(DATA_WIDTH, H, W, F, K)-1:0] frame_in,
  output logic [DATA_WIDTH-1:0]                   m_data,
  output logic                                    m_valid,
  input  logic                                    m_ready,
  output logic                                    m_row_last,
  output logic                                    m_map_last,
  output logic                                    m_frame_last,
  output logic [cw(K)-1:0]                        m_map_idx,
  output logic                                    busy,
  output logic                                    done,
  output logic                                    overrun
);

  localparam int OH    = H - F + 1;
  localparam int OW    = W - F + 1;
  localparam int MAPSZ = OH * OW;
  localparam int NELEM = K * MAPSZ;
  localparam int CW    = cw(OW);
  localparam int RW    = cw(OH);
  localparam int MW    = cw(K);
  localparam int EW    = cw(NELEM);

  state_t                        state_q;
  logic                          valid_q, busy_q, done_q, overrun_q;
  logic [DATA_WIDTH-1:0]         data_q;
  logic [NELEM*DATA_WIDTH-1:0]   buf_q;

  logic [CW-1:0]                 cnt_c;
  logic [RW-1:0]                 cnt_r;
  logic [MW-1:0]                 cnt_m;
  logic                          row_last, map_last, frame_last;
  logic                          accept, beat;
  logic [EW-1:0]                 cur_e, nxt_e;
  logic [DATA_WIDTH-1:0]         nxt_elem;

  function automatic logic [DATA_WIDTH-1:0] relu_fn(input logic signed [DATA_WIDTH-1:0] x);
    if (RELU != 0 && x < 0) return '0;
    return x;
  endfunction

  assign accept = start & (state_q == ST_IDLE);
  assign beat   = valid_q & m_ready;

  conv_stream_counter #(
    .NC (OW),
    .NR (OH),
    .NM (K)
  ) u_cnt (
    .clk_i        (clk),
    .rst_i        (reset),
    .clr_i        (accept),
    .en_i         (beat),
    .c_o          (cnt_c),
    .r_o          (cnt_r),
    .m_o          (cnt_m),
    .row_last_o   (row_last),
    .map_last_o   (map_last),
    .frame_last_o (frame_last)
  );

  // The register always holds the element at the current counter position, so
  // on a beat it is reloaded with the one following it in stream order.
  always_comb begin
    cur_e    = EW'(cnt_m) * EW'(MAPSZ) + EW'(cnt_r) * EW'(OW) + EW'(cnt_c);
    nxt_e    = cur_e + 1'b1;
    nxt_elem = '0;
    for (int i = 0; i < NELEM; i++) begin
      if (nxt_e == EW'(i)) nxt_elem = buf_q[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (accept) buf_q <= frame_in;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
      data_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q <= ST_STREAM;
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
            data_q  <= relu_fn(frame_in[DATA_WIDTH-1:0]);
          end
        end
        ST_STREAM: begin
          if (start) overrun_q <= 1'b1;
          if (beat) begin
            if (frame_last) begin
              state_q <= ST_IDLE;
              valid_q <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              data_q <= relu_fn(nxt_elem);
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign m_data       = data_q;
  assign m_valid      = valid_q;
  assign m_row_last   = valid_q & row_last;
  assign m_map_last   = valid_q & map_last;
  assign m_frame_last = valid_q & frame_last;
  assign m_map_idx    = cnt_m;
  assign busy         = busy_q;
  assign done         = done_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_conv_output_streamer.sv
// Bench for conv_output_streamer: a stream-order reference model checks the
// default instance every cycle; ReLU and 1x1-map instances get directed checks.
module tb_conv_output_streamer;

  localparam int DW    = 8;
  localparam int OW    = 6;
  localparam int MAPSZ = 36;
  localparam int NE    = 216;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Default instance
  logic             start0, ready0;
  logic [NE*DW-1:0] frame0;
  logic [DW-1:0]    data0;
  logic             valid0, row0, map0, frm0, busy0, done0, ovr0;
  logic [2:0]       idx0;

  // ReLU instance
  logic             start1, ready1;
  logic [NE*DW-1:0] frame1;
  logic [DW-1:0]    data1;
  logic             valid1, row1, map1, frm1, busy1, done1, ovr1;
  logic [2:0]       idx1;

  // Single 1x1 map instance
  logic             start2, ready2;
  logic [DW-1:0]    frame2;
  logic [DW-1:0]    data2;
  logic             valid2, row2, map2, frm2, busy2, done2, ovr2;
  logic [0:0]       idx2;

  conv_output_streamer dut0 (
    .clk(clk), .reset(reset), .start(start0), .frame_in(frame0),
    .m_data(data0), .m_valid(valid0), .m_ready(ready0),
    .m_row_last(row0), .m_map_last(map0), .m_frame_last(frm0),
    .m_map_idx(idx0), .busy(busy0), .done(done0), .overrun(ovr0)
  );

  conv_output_streamer #(.RELU(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .frame_in(frame1),
    .m_data(data1), .m_valid(valid1), .m_ready(ready1),
    .m_row_last(row1), .m_map_last(map1), .m_frame_last(frm1),
    .m_map_idx(idx1), .busy(busy1), .done(done1), .overrun(ovr1)
  );

  conv_output_streamer #(.H(3), .W(3), .K(1)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .frame_in(frame2),
    .m_data(data2), .m_valid(valid2), .m_ready(ready2),
    .m_row_last(row2), .m_map_last(map2), .m_frame_last(frm2),
    .m_map_idx(idx2), .busy(busy2), .done(done2), .overrun(ovr2)
  );

  int ntests = 0;
  int nfail  = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model of the default instance, advanced once per cycle from the
  // inputs that the coming clock edge will see.
  bit   mdl_active, mdl_done, mdl_ov;
  int   mdl_e;
  int   snap [NE];
  int   seen [NE];
  int   nbeats, ndone, nrow, nmap, nframe, last_idx;
  bit   stall_prev;
  logic [13:0] prev_out;

  always @(negedge clk) begin
    if (reset) begin
      chk("rst_valid", valid0, 0);
      chk("rst_busy", busy0, 0);
      chk("rst_done", done0, 0);
      chk("rst_overrun", ovr0, 0);
      chk("rst_data", data0, 0);
      chk("rst_flags", {row0, map0, frm0}, 0);
      chk("rst_idx", idx0, 0);
      mdl_active = 0;
      mdl_done   = 0;
      mdl_ov     = 0;
      mdl_e      = 0;
      stall_prev = 0;
    end else begin
      chk("valid", valid0, mdl_active);
      chk("busy", busy0, mdl_active);
      chk("done", done0, mdl_done);
      chk("overrun", ovr0, mdl_ov);
      if (mdl_active) begin
        chk("data", data0, snap[mdl_e]);
        chk("row_last", row0, (mdl_e % OW) == OW - 1);
        chk("map_last", map0, (mdl_e % MAPSZ) == MAPSZ - 1);
        chk("frame_last", frm0, mdl_e == NE - 1);
        chk("map_idx", idx0, mdl_e / MAPSZ);
      end
      if (stall_prev) chk("stall_hold", {data0, row0, map0, frm0, idx0}, prev_out);
      if (done0) ndone++;
      if (valid0 && ready0 && nbeats < NE) begin
        seen[nbeats] = data0;
        nbeats++;
        nrow   += row0;
        nmap   += map0;
        nframe += frm0;
        if (frm0) last_idx = idx0;
      end
      stall_prev = valid0 && !ready0;
      prev_out   = {data0, row0, map0, frm0, idx0};

      mdl_done = 0;
      if (!mdl_active) begin
        if (start0) begin
          for (int i = 0; i < NE; i++) snap[i] = frame0[i*DW +: DW];
          mdl_e      = 0;
          mdl_active = 1;
          nbeats = 0; nrow = 0; nmap = 0; nframe = 0; last_idx = -1;
        end
      end else begin
        if (start0) mdl_ov = 1;
        if (ready0) begin
          if (mdl_e == NE - 1) begin
            mdl_active = 0;
            mdl_done   = 1;
          end else begin
            mdl_e++;
          end
        end
      end
    end
  end

  task automatic wait_done0(input string name, input int budget);
    int n0;
    bit got;
    n0  = ndone;
    got = 0;
    for (int k = 0; k < budget && !got; k++) begin
      step();
      if (ndone > n0) got = 1;
    end
    chk(name, got, 1);
  endtask

  task automatic wait_beats0(input string name, input int target);
    bit got;
    got = 0;
    for (int k = 0; k < 600 && !got; k++) begin
      if (nbeats >= target) got = 1;
      else step();
    end
    chk(name, got, 1);
  endtask

  initial begin
    reset  = 1'b1;
    start0 = 0; ready0 = 0; frame0 = '0;
    start1 = 0; ready1 = 0; frame1 = '0;
    start2 = 0; ready2 = 0; frame2 = '0;
    nbeats = 0; ndone = 0; nrow = 0; nmap = 0; nframe = 0; last_idx = -1;
    repeat (3) step();
    chk("reset_lit_valid", valid0, 0);
    reset = 1'b0;
    step();

    // In-order stream with a continuously ready sink
    for (int i = 0; i < NE; i++) frame0[i*DW +: DW] = 8'(i % 256);
    ready0 = 1;
    ndone  = 0;
    chk("t1_idle_before", valid0, 0);
    start0 = 1;
    step();
    start0 = 0;
    chk("t1_latency", valid0, 1);
    wait_done0("t1_done_seen", 400);
    chk("t1_beats", nbeats, 216);
    chk("t1_first", seen[0], 0);
    chk("t1_beat37", seen[36], 36);
    chk("t1_last", seen[215], 215);
    chk("t1_row_cnt", nrow, 36);
    chk("t1_map_cnt", nmap, 6);
    chk("t1_frame_cnt", nframe, 1);
    chk("t1_last_idx", last_idx, 5);
    step();
    chk("t1_done_once", ndone, 1);
    chk("t1_busy_after", busy0, 0);

    // Random backpressure
    start0 = 1;
    ready0 = 1'($urandom_range(0, 1));
    step();
    start0 = 0;
    begin
      int n0;
      bit got;
      n0 = ndone; got = 0;
      for (int k = 0; k < 3000 && !got; k++) begin
        ready0 = 1'($urandom_range(0, 1));
        step();
        if (ndone > n0) got = 1;
      end
      chk("t2_done_seen", got, 1);
    end
    chk("t2_beats", nbeats, 216);
    chk("t2_beat100", seen[100], 100);
    ready0 = 1;
    step();

    // ReLU: negative elements clamp to zero
    for (int i = 0; i < NE; i++) frame1[i*DW +: DW] = (i % 2 == 0) ? 8'h85 : 8'h05;
    ready1 = 1;
    start1 = 1;
    step();
    start1 = 0;
    chk("t3_valid", valid1, 1);
    chk("t3_d0", data1, 0);
    step();
    chk("t3_d1", data1, 5);
    step();
    chk("t3_d2", data1, 0);
    step();
    chk("t3_d3", data1, 5);
    begin
      bit got;
      got = 0;
      for (int k = 0; k < 300 && !got; k++) begin
        step();
        if (done1) got = 1;
      end
      chk("t3_done_seen", got, 1);
    end

    // Start while streaming is ignored and flagged
    for (int i = 0; i < NE; i++) frame0[i*DW +: DW] = 8'(i % 256);
    start0 = 1;
    step();
    start0 = 0;
    wait_beats0("t4_reach10", 10);
    for (int i = 0; i < NE; i++) frame0[i*DW +: DW] = ~8'(i % 256);
    start0 = 1;
    step();
    start0 = 0;
    chk("t4_overrun", ovr0, 1);
    wait_done0("t4_done_seen", 400);
    chk("t4_beats", nbeats, 216);
    chk("t4_beat20", seen[20], 20);
    step();
    chk("t4_overrun_sticky", ovr0, 1);

    // Reset mid-stream, then a clean restart
    for (int i = 0; i < NE; i++) frame0[i*DW +: DW] = 8'((i + 7) % 256);
    start0 = 1;
    step();
    start0 = 0;
    wait_beats0("t5_reach100", 100);
    begin
      int nd;
      nd = ndone;
      reset = 1;
      #1;
      chk("t5_valid_drop", valid0, 0);
      chk("t5_busy_drop", busy0, 0);
      chk("t5_idx_drop", idx0, 0);
      chk("t5_overrun_clr", ovr0, 0);
      step();
      reset = 0;
      repeat (3) step();
      chk("t5_no_done", ndone, nd);
    end
    start0 = 1;
    step();
    start0 = 0;
    chk("t5_restart_d0", data0, 7);
    wait_done0("t5_done_seen", 400);
    chk("t5_beats", nbeats, 216);

    // Single 1x1 map: one beat carries every marker
    frame2 = 8'hF3;
    ready2 = 1;
    start2 = 1;
    step();
    start2 = 0;
    chk("t6_valid", valid2, 1);
    chk("t6_data", data2, 8'hF3);
    chk("t6_flags", {row2, map2, frm2}, 3'b111);
    chk("t6_idx", idx2, 0);
    step();
    chk("t6_valid_off", valid2, 0);
    chk("t6_done", done2, 1);
    step();
    chk("t6_done_pulse", done2, 0);
    chk("t6_busy", busy2, 0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/conv_output_streamer.md
Name: conv_output_streamer

Overview:
- Consumer end of the multi-filter convolution layer's flat output bus.
- On a start pulse, snapshots all K output feature maps (each (H-F+1)x(W-F+1) elements of DATA_WIDTH) into an internal frame buffer.
- Streams the buffer out one element per accepted beat over a valid/ready interface, in map-major, row-major order, with end-of-row, end-of-map and end-of-frame markers.
- Decouples the wide parallel conv result from serial downstream logic (pooling, memory writer, host link).

Parameters:
- DATA_WIDTH, 8, bits per element (two's complement)
- H, 8, input image height
- W, 8, input image width
- F, 3, filter size; OH = H-F+1, OW = W-F+1
- K, 6, number of feature maps in the frame
- RELU, 0, 1 = output max(x,0) per element; 0 = pass through

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  one-cycle pulse: frame_in is valid, capture it
- frame_in  input  K*OH*OW*DATA_WIDTH  flat frame, vector [0:N-1]; element e = m*OH*OW + r*OW + c at bits [e*DATA_WIDTH +: DATA_WIDTH]
- m_data  output  DATA_WIDTH  current element
- m_valid  output  1  m_data valid
- m_ready  input  1  downstream accepts
- m_row_last  output  1  element is c = OW-1
- m_map_last  output  1  element is r = OH-1, c = OW-1
- m_frame_last  output  1  element is the last of map K-1
- m_map_idx  output  clog2(K) (min 1)  map index of current element
- busy  output  1  frame held or streaming
- done  output  1  one-cycle pulse after the final beat is accepted
- overrun  output  1  sticky: start arrived while busy

Behaviour:
- Reset (async): state IDLE; all counters 0; m_valid, busy, done, overrun, all last flags and m_map_idx 0; m_data 0. Buffer contents don't care.
- IDLE: m_valid=0, busy=0. On start: register frame_in into the buffer at that edge; m, r, c = 0; go STREAM.
- STREAM: busy=1, m_valid=1.
  - m_data = buffer element (m,r,c), ReLU applied if RELU=1.
  - Outputs are registered from the buffer and counters: first m_valid is the cycle after start (latency 1).
  - m_data and the markers stay stable while m_valid && !m_ready.
  - Beat = m_valid && m_ready. On a beat: c++. At c=OW-1, c=0 and r++. At r=OH-1, r=0 and m++.
  - On the beat where m_frame_last=1: go IDLE, m_valid=0 next cycle, done=1 for exactly that cycle.
- Total beats per frame = K*OH*OW (216 at defaults). Counters never wrap within a frame.
- start while busy (including the done cycle's preceding beat): ignored, buffer unchanged, overrun set. overrun clears only on reset.
- start in the same cycle the final beat is accepted: treated as busy, so ignored and overrun set.
- m_ready may be high while m_valid=0; no effect.
- Reset mid-stream: immediate abort; m_valid drops asynchronously; no done pulse.
- ReLU: negative (MSB=1) becomes 0; non-negative unchanged; width unchanged.
- Element select: indexed part-select from a combinational index m*OH*OW + r*OW + c, or an equivalent running element counter. Either form must yield the same ordering.

Decomposition:
- Shared package: derived constants OH, OW, MAPSZ = OH*OW, NELEM = K*MAPSZ; counter widths via clog2; state encoding (IDLE, STREAM).
- Shared with the conv layer so the bus layout has a single definition.
- One natural sub-module: conv_stream_counter, a 3-level nested (c, r, m) counter with enable/clear and last-flag outputs, reusable by a future input loader.

Test Plan:
- Defaults, frame element e = e mod 256, start, m_ready=1 constantly -> 216 beats on consecutive cycles starting 1 cycle after start:
  - data 0..215 in order
  - m_row_last on every 6th beat
  - m_map_last on beats 36, 72, …, 216
  - m_frame_last and m_map_idx=5 on beat 216
  - done pulses once, busy low afterwards.
- Random m_ready (50%) -> identical data sequence; m_data and flags held constant during every stall; beat count 216.
- RELU=1, frame alternating 8'h85 / 8'h05 -> output alternates 0 / 5.
- Second start at beat 10, with frame_in changed -> stream continues with the original frame, overrun=1 and stays 1 after done.
- Reset asserted at beat 100 -> m_valid, busy and the counters go to 0 immediately, no done. A new start then streams from element 0.
- K=1, H=W=3 (1x1 map) -> single beat with m_row_last, m_map_last and m_frame_last all 1, done the following cycle.
